// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Stall/flush sequencer for the 16-bit 5-stage pipeline.
//                Drives the PC / IF_ID / ID_EX / EX_MEM / MEM_WB write
//                enables and the IF_ID / ID_EX flushes. It resolves
//                load-use hazards, taken branches and a variable-latency
//                data-memory handshake, and halts on a memory timeout.
//  Ports       : CLK, Reset (async, active-high)
//                IDRs1/IDRs1Used, IDRs2/IDRs2Used  - ID-stage sources
//                EXRd/EXRegWrite/EXMemRead          - EX-stage destination
//                BranchTaken                        - taken branch in EX
//                MemReq/MemAck                      - data-memory handshake
//                PCWrite..MEMWBWrite                - stage enables
//                IFIDFlush/IDEXFlush                - bubble insertion
//                MemTimeout                         - sticky timeout flag
//                StallCount                         - saturating PC-stall count
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int REG_AW      = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [REG_AW-1:0] IDRs1,
  input  logic              IDRs1Used,
  input  logic [REG_AW-1:0] IDRs2,
  input  logic              IDRs2Used,
  input  logic [REG_AW-1:0] EXRd,
  input  logic              EXRegWrite,
  input  logic              EXMemRead,
  input  logic              BranchTaken,
  input  logic              MemReq,
  input  logic              MemAck,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IDEXWrite,
  output logic              EXMEMWrite,
  output logic              MEMWBWrite,
  output logic              IFIDFlush,
  output logic              IDEXFlush,
  output logic              MemTimeout,
  output logic [CNT_W-1:0]  StallCount
);

  // Wait counter only ever holds 0..MEM_TIMEOUT-1.
  localparam int c_WW = $clog2(MEM_TIMEOUT);
  localparam logic [c_WW-1:0] c_WAIT_LAST = c_WW'(MEM_TIMEOUT - 1);
  localparam logic [c_WW-1:0] c_WAIT_ONE  = c_WW'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_WW-1:0]   r_wait_cnt;
  logic [c_WW-1:0]   w_wait_nxt;
  logic              r_timeout;
  logic              w_timeout_set;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_ms;
  logic              w_lu;

  assign w_ms = MemReq & ~MemAck;

  // Register 0 is an ordinary register here, so an EXRd==0 match stalls too.
  assign w_lu = EXMemRead & EXRegWrite &
                ((IDRs1Used & (IDRs1 == EXRd)) | (IDRs2Used & (IDRs2 == EXRd)));

  always_comb begin
    PCWrite       = 1'b0;
    IFIDWrite     = 1'b0;
    IDEXWrite     = 1'b0;
    EXMEMWrite    = 1'b0;
    MEMWBWrite    = 1'b0;
    IFIDFlush     = 1'b0;
    IDEXFlush     = 1'b0;
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_set = 1'b0;

    if (!Reset) begin
      case (r_state)
        ST_HALT: begin
          // Frozen until Reset; everything stays at its default of 0.
        end
        ST_RUN, ST_MEM_WAIT: begin
          if (w_ms) begin
            // Whole pipe freezes: defaults already hold all enables low.
            if (r_state == ST_RUN) begin
              w_state_nxt = ST_MEM_WAIT;
              w_wait_nxt  = c_WAIT_ONE;
            end else if (r_wait_cnt == c_WAIT_LAST) begin
              w_state_nxt   = ST_HALT;
              w_timeout_set = 1'b1;
            end else begin
              w_wait_nxt = r_wait_cnt + c_WAIT_ONE;
            end
          end else begin
            // The ack cycle of MEM_WAIT is decoded exactly like RUN.
            w_state_nxt = ST_RUN;
            w_wait_nxt  = '0;
            if (BranchTaken) begin
              // Squashing the ID instruction makes any load-use moot.
              PCWrite    = 1'b1;
              IFIDWrite  = 1'b1;
              IDEXWrite  = 1'b1;
              EXMEMWrite = 1'b1;
              MEMWBWrite = 1'b1;
              IFIDFlush  = 1'b1;
              IDEXFlush  = 1'b1;
            end else if (w_lu) begin
              // Hold IF/ID, drop one bubble into EX; the load then moves
              // to MEM and the hazard cannot repeat.
              IDEXWrite  = 1'b1;
              IDEXFlush  = 1'b1;
              EXMEMWrite = 1'b1;
              MEMWBWrite = 1'b1;
            end else begin
              PCWrite    = 1'b1;
              IFIDWrite  = 1'b1;
              IDEXWrite  = 1'b1;
              EXMEMWrite = 1'b1;
              MEMWBWrite = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_timeout  <= r_timeout | w_timeout_set;
      if (!PCWrite && (r_state != ST_HALT) && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign MemTimeout = r_timeout;
  assign StallCount = r_stall_cnt;

endmodule
`default_nettype wire
